fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sources the instruction fields consumed by the control unit (op, funct3, funct7[5]) and consumes its PCSrc branch decision. Holds the program counter, issues one-at-a-time requests to instruction memory over a valid/ready request and valid-only response interface, and registers the returned word. It presents the word to decode and execute until the datapath accepts it, then computes the next PC: sequential, or branch target when PCSrc is set.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- NOP_INSTR, 32'h0000_0013, value of instr while no fetched word is held (addi x0,x0,0)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  fetch address, equals pc
- imem_rsp_valid  in  1  response data valid, one cycle per response
- imem_rdata  in  32  returned instruction word
- stall  in  1  datapath not ready to retire held instruction
- PCSrc  in  1  take branch for the held instruction
- ImmExt  in  32  sign-extended branch offset for the held instruction
- instr_valid  out  1  instr holds a fetched, unretired word
- instr  out  32  held instruction
- pc  out  32  address of held or requested instruction
- pc_plus4  out  32  pc + 4
- op  out  7  instr[6:0]
- funct3  out  3  instr[14:12]
- funct7  out  1  instr[30]
- rd, rs1, rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]
- fetch_misaligned  out  1  sticky misaligned-target fault (see Configuration)

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: reset state; unconditionally goes to REQ on the next edge.
- REQ: imem_req_valid=1, imem_addr=pc. If imem_req_ready, go to WAIT.
- WAIT: when imem_rsp_valid is high, capture imem_rdata into instr, set instr_valid, go to HOLD.
- HOLD: stall=1 holds everything. stall=0 retires the instruction:
  - pc <= PCSrc ? pc+ImmExt : pc+4
  - instr_valid <= 0, instr <= NOP_INSTR
  - go to REQ, or to FAULT per Configuration.
- FAULT: terminal until reset. No requests; instr_valid=0.
- One request outstanding at most. imem_rsp_valid outside WAIT is ignored.
- PCSrc and ImmExt are sampled only in the HOLD cycle where stall=0.
- All address arithmetic is modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0, with no flag.
- op/funct3/funct7/rd/rs1/rs2 are combinational slices of the instr register. pc_plus4 is combinational from pc.

## Timing
- Reset values: pc=RESET_PC, instr=NOP_INSTR, instr_valid=0, imem_req_valid=0, fetch_misaligned=0, state=IDLE.
- imem_req_valid is a decode of the state register; it has no combinational path from inputs.
- First request: imem_req_valid rises one cycle after rst_n deasserts.
- Memory must return the response no earlier than the cycle after acceptance.
- instr_valid rises the cycle after the imem_rsp_valid cycle.
- Zero-wait throughput: 3 cycles per instruction (REQ, WAIT, HOLD).
- Reset asserted mid-transaction aborts it immediately. The memory side must drop any in-flight response.
- In REQ with imem_req_ready=0, imem_addr stays stable until accepted.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - On retire, a next PC with [1:0]≠0 is not loaded.
  - fetch_misaligned sets (sticky) and the FSM enters FAULT.
- FETCH_ALIGN_CHECK_EN undefined:
  - Next PC has bits [1:0] forced to 00.
  - fetch_misaligned is tied 0 and FAULT is unreachable.

## Test plan
- Reset/first fetch: release rst_n with ready=1 and 1-cycle response 32'h0052_8293. imem_addr=0 one cycle after release. instr_valid two cycles after acceptance, with op=7'h13, rd=5, rs1=5, funct3=0.
- Sequential stream: zero-wait memory, stall=0, PCSrc=0. Addresses 0,4,8,C appear exactly 3 cycles apart.
- Stall hold: stall=1 for 5 cycles in HOLD. instr, pc and instr_valid are unchanged and imem_req_valid stays 0. After release, the next address is pc+4.
- Branch: held at pc=32'h10 with PCSrc=1, ImmExt=32'hFFFF_FFF0 and stall=0. The next imem_addr is 0. Repeat at pc=32'hFFFF_FFFC with PCSrc=0: the next address is 0.
- Backpressure/reset: ready=0 for 4 cycles leaves imem_addr stable. Then assert rst_n low during WAIT: all outputs return to reset values asynchronously, and a late rsp_valid is ignored.
- Misaligned target: ImmExt=32'h2 taken from pc=0.
  - With FETCH_ALIGN_CHECK_EN: fetch_misaligned=1, no further requests.
  - Without it: next address is 0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one request at a time to instruction memory, and holds the word until decode retires it.
// Optional FETCH_ALIGN_CHECK_EN: a misaligned retire target raises sticky fetch_misaligned and parks the FSM in FAULT.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic        fetch_misaligned
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] next_pc_raw;

  // PCSrc/ImmExt only matter in the HOLD cycle that retires; elsewhere this value is discarded.
  assign next_pc_raw = PCSrc ? (pc_q + ImmExt) : (pc_q + 32'd4);

`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  logic target_misaligned;
  assign target_misaligned = |next_pc_raw[1:0];
`else
  logic unused_next_pc_low;
  assign unused_next_pc_low = ^next_pc_raw[1:0];
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misaligned_d  = misaligned_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          instr_d       = NOP_INSTR;
          instr_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
          if (target_misaligned) begin
            misaligned_d = 1'b1;
            state_d      = S_FAULT;
          end else begin
            pc_d    = next_pc_raw;
            state_d = S_REQ;
          end
`else
          pc_d    = {next_pc_raw[31:2], 2'b00};
          state_d = S_REQ;
`endif
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misaligned_q <= 1'b0;
    else        misaligned_q <= misaligned_d;
  end
  assign fetch_misaligned = misaligned_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

  // Request valid is a pure state decode: no input reaches it combinationally.
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_addr      = pc_q;
  assign pc             = pc_q;
  assign pc_plus4       = pc_q + 32'd4;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign op             = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7         = instr_q[30];
  assign rd             = instr_q[11:7];
  assign rs1            = instr_q[19:15];
  assign rs2            = instr_q[24:20];

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_valid && !imem_req_ready) |=> (imem_req_valid && $stable(imem_addr)));

  a_valid_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    instr_valid_q == (state_q == S_HOLD));

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a memory/datapath driver keeps an address-level model of the PC,
// pushes expected held words into a queue, and a separate monitor pops and compares them.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] ImmExt = 32'h0;
  logic        instr_valid;
  logic [31:0] instr, pc, pc_plus4;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [4:0]  rd, rs1, rs2;
  logic        fetch_misaligned;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .stall(stall), .PCSrc(PCSrc), .ImmExt(ImmExt),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
    .op(op), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .fetch_misaligned(fetch_misaligned)
  );

  typedef struct { int ready_delay; int lat; logic [31:0] data; } mem_txn_t;
  typedef struct { int stall_cycles; logic pcsrc; logic [31:0] imm; } dec_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { int cyc; logic [31:0] addr; } acc_t;

  mem_txn_t mem_q[$];
  dec_t     dec_q[$];
  exp_t     exp_q[$];
  acc_t     acc_log[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int retired = 0;

  logic [31:0] model_pc = RESET_PC;
  logic        model_fault = 1'b0;
  bit          force_junk = 1'b0;

  mem_txn_t    cur_txn;
  dec_t        cur_dec;
  bit          have_txn = 1'b0;
  bit          have_dec = 1'b0;
  bit          outstanding = 1'b0;
  int          lat_left = 0;
  logic [31:0] rsp_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory and datapath driver; also owns the reference PC model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        stall          = 1'b0;
        PCSrc          = 1'b0;
        ImmExt         = 32'h0;
        outstanding    = 1'b0;
        have_txn       = 1'b0;
        have_dec       = 1'b0;
        model_pc       = RESET_PC;
        model_fault    = 1'b0;
        exp_q.delete();
      end else begin
        bit busy;
        logic [31:0] nxt;
        busy = outstanding;
        imem_req_ready = 1'($urandom_range(0, 1));
        imem_rsp_valid = 1'b0;
        imem_rdata     = $urandom;
        if (outstanding) begin
          lat_left--;
          if (lat_left == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rdata     = rsp_data;
            exp_q.push_back('{model_pc, rsp_data});
            outstanding    = 1'b0;
          end
        end else if (force_junk || $urandom_range(0, 3) == 0) begin
          imem_rsp_valid = 1'b1;
          force_junk     = 1'b0;
        end

        if (imem_req_valid) begin
          check("req_addr", imem_addr, model_pc);
          check("req_while_busy", 32'(busy | model_fault), 32'd0);
          if (!have_txn) begin
            if (mem_q.size() != 0) cur_txn = mem_q.pop_front();
            else cur_txn = '{($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3)),
                             int'($urandom_range(1, 4)), $urandom};
            have_txn = 1'b1;
          end
          if (cur_txn.ready_delay == 0) begin
            imem_req_ready = 1'b1;
            outstanding    = 1'b1;
            lat_left       = cur_txn.lat;
            rsp_data       = cur_txn.data;
            have_txn       = 1'b0;
            acc_log.push_back('{cyc, model_pc});
          end else begin
            imem_req_ready = 1'b0;
            cur_txn.ready_delay--;
          end
        end

        if (instr_valid) begin
          if (!have_dec) begin
            if (dec_q.size() != 0) cur_dec = dec_q.pop_front();
            else begin
              cur_dec.stall_cycles = int'($urandom_range(0, 3));
              cur_dec.pcsrc        = 1'($urandom_range(0, 1));
              cur_dec.imm          = (32'($urandom_range(0, 511)) - 32'd256) << 2;
`ifndef FETCH_ALIGN_CHECK_EN
              if ($urandom_range(0, 7) == 0) cur_dec.imm = cur_dec.imm + 32'($urandom_range(1, 3));
`endif
            end
            have_dec = 1'b1;
          end
          if (cur_dec.stall_cycles > 0) begin
            stall  = 1'b1;
            PCSrc  = 1'($urandom_range(0, 1));
            ImmExt = $urandom;
            cur_dec.stall_cycles--;
          end else begin
            stall  = 1'b0;
            PCSrc  = cur_dec.pcsrc;
            ImmExt = cur_dec.imm;
            nxt = cur_dec.pcsrc ? model_pc + cur_dec.imm : model_pc + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
            if (nxt % 4 != 0) model_fault = 1'b1;
            else model_pc = nxt;
`else
            model_pc = nxt - (nxt % 4);
`endif
            have_dec = 1'b0;
            retired++;
          end
        end else begin
          stall  = 1'($urandom_range(0, 1));
          PCSrc  = 1'($urandom_range(0, 1));
          ImmExt = $urandom;
        end
      end
    end
  end

  // Monitor: pops the expected word each time a new instruction is presented.
  initial begin
    bit   prev_v = 1'b0;
    bit   have_cur = 1'b0;
    exp_t cur;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        prev_v   = 1'b0;
        have_cur = 1'b0;
        continue;
      end
      check("one_outstanding", 32'(imem_req_valid & instr_valid), 32'd0);
      check("fetch_misaligned", 32'(fetch_misaligned), 32'(model_fault));
      if (instr_valid && !prev_v) begin
        check("exp_available", 32'(exp_q.size() != 0), 32'd1);
        have_cur = (exp_q.size() != 0);
        if (have_cur) begin
          cur = exp_q.pop_front();
          check("pc_plus4", pc_plus4, cur.pc + 32'd4);
          check("op", 32'(op), 32'(cur.data[6:0]));
          check("funct3", 32'(funct3), 32'(cur.data[14:12]));
          check("funct7", 32'(funct7), 32'(cur.data[30]));
          check("rd", 32'(rd), 32'(cur.data[11:7]));
          check("rs1", 32'(rs1), 32'(cur.data[19:15]));
          check("rs2", 32'(rs2), 32'(cur.data[24:20]));
        end
      end
      if (instr_valid && have_cur) begin
        check("instr", instr, cur.data);
        check("pc", pc, cur.pc);
      end else if (!instr_valid) begin
        check("instr_nop", instr, NOP_INSTR);
      end
      prev_v = instr_valid;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_instr"}, instr, NOP_INSTR);
    check({tag, "_op"}, 32'(op), 32'h13);
    check({tag, "_misaligned"}, 32'(fetch_misaligned), 32'd0);
  endtask

  task automatic wait_held(input logic [31:0] a);
    int n = 0;
    while (!(instr_valid && pc == a) && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("wait_held_timeout", 32'(n < 500), 32'd1);
  endtask

  task automatic wait_acc(input int cnt);
    int n = 0;
    while (acc_log.size() < cnt && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("wait_acc_timeout", 32'(acc_log.size() >= cnt), 32'd1);
  endtask

  initial begin
    int r0;
    int n;
    int n0;
    rst_n = 1'b0;
    mem_q.push_back('{0, 1, 32'h0052_8293});
    dec_q.push_back('{0, 1'b0, 32'h0});
    mem_q.push_back('{0, 1, 32'h0041_0113});
    dec_q.push_back('{0, 1'b0, 32'h0});
    mem_q.push_back('{0, 1, 32'h4020_81B3});
    dec_q.push_back('{0, 1'b0, 32'h0});
    mem_q.push_back('{0, 1, 32'h0032_0233});
    dec_q.push_back('{5, 1'b0, 32'h0});
    mem_q.push_back('{0, 1, 32'hFE20_8EE3});
    dec_q.push_back('{0, 1'b1, 32'hFFFF_FFF0});
    mem_q.push_back('{0, 1, 32'h0000_0063});
    dec_q.push_back('{0, 1'b1, 32'hFFFF_FFFC});
    mem_q.push_back('{0, 1, 32'h0015_0513});
    dec_q.push_back('{0, 1'b0, 32'h0});
    mem_q.push_back('{4, 3, 32'hDEAD_BEEF});

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("rst");
    check("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    @(posedge clk);
    #2;
    check("first_wait_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #2;
    check("first_instr_valid", 32'(instr_valid), 32'd1);
    check("first_op", 32'(op), 32'h13);
    check("first_rd", 32'(rd), 32'd5);
    check("first_rs1", 32'(rs1), 32'd5);
    check("first_funct3", 32'(funct3), 32'd0);

    wait_acc(4);
    for (int i = 0; i < 4; i++) begin
      check("seq_addr", acc_log[i].addr, 32'(i * 4));
      if (i > 0) check("seq_spacing", 32'(acc_log[i].cyc - acc_log[i-1].cyc), 32'd3);
    end

    wait_held(32'hC);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      check("stall_instr", instr, 32'h0032_0233);
      check("stall_pc", pc, 32'hC);
      check("stall_valid", 32'(instr_valid), 32'd1);
      check("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    wait_acc(5);
    check("after_stall_addr", acc_log[4].addr, 32'h10);
    check("after_stall_spacing", 32'(acc_log[4].cyc - acc_log[3].cyc), 32'd8);

    wait_acc(6);
    check("branch_back_addr", acc_log[5].addr, 32'h0);
    wait_acc(7);
    check("branch_neg_addr", acc_log[6].addr, 32'hFFFF_FFFC);
    wait_acc(8);
    check("wrap_addr", acc_log[7].addr, 32'h0);
    check("backpressure_spacing", 32'(acc_log[7].cyc - acc_log[6].cyc), 32'd7);

    // Now in WAIT with the response still three cycles away.
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    force_junk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_acc(9);
    check("post_reset_addr", acc_log[8].addr, RESET_PC);

    r0 = retired;
    n = 0;
    while (retired < r0 + 150 && n < 30000) begin
      @(posedge clk);
      n++;
    end
    check("random_progress", 32'(retired >= r0 + 150), 32'd1);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    mem_q.push_back('{0, 1, 32'h0000_0013});
    dec_q.push_back('{0, 1'b1, 32'h0000_0002});
    repeat (2) @(posedge clk);
    n0 = acc_log.size();
    @(negedge clk);
    rst_n = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
    wait_acc(n0 + 1);
    repeat (20) @(posedge clk);
    #2;
    check("misalign_flag", 32'(fetch_misaligned), 32'd1);
    check("misalign_no_req", 32'(acc_log.size()), 32'(n0 + 1));
    check("misalign_req_valid", 32'(imem_req_valid), 32'd0);
    check("misalign_instr_valid", 32'(instr_valid), 32'd0);
`else
    wait_acc(n0 + 2);
    check("misalign_first_addr", acc_log[n0].addr, 32'h0);
    check("misalign_forced_addr", acc_log[n0 + 1].addr, 32'h0);
    check("misalign_flag_tied", 32'(fetch_misaligned), 32'd0);
`endif
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
